// File: rtl/crc16_frame_sched.sv
// crc16_frame_sched
// Round-robin front end for a bit-serial CRC-16 (poly 0x1021) engine.
// Two requesters stream WORD_W-bit words; the winner owns the engine for a
// whole frame. Each word is shifted MSB-first, one bit per clock, and the
// final CRC is offered on a valid/ready result port.
//
// Build option:
//   CRC16_SCHED_INIT_ONES_EN  defined   -> per-frame seed 0xFFFF
//                             undefined -> per-frame seed 0x0000
module crc16_frame_sched #(
    parameter int WORD_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req_valid,
    input  logic [2*WORD_W-1:0]   req_data,
    input  logic [1:0]            req_last,
    output logic [1:0]            req_ready,
    output logic                  crc_valid,
    output logic [15:0]           crc_out,
    output logic                  crc_id,
    input  logic                  crc_ready,
    output logic                  busy
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [15:0] POLY = 16'h1021;
`ifdef CRC16_SCHED_INIT_ONES_EN
    localparam logic [15:0] SEED = 16'hFFFF;
`else
    localparam logic [15:0] SEED = 16'h0000;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // One serial CRC step: feed bit b into register c.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        crc_step = {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    endfunction

    // One-hot ready pattern for a given requester.
    function automatic logic [1:0] onehot(input logic sel);
        onehot = sel ? 2'b10 : 2'b01;
    endfunction

    state_t              state_r;
    logic                grant_r;
    logic                last_grant_r;
    logic                first_r;
    logic                last_r;
    logic [WORD_W-1:0]   word_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [15:0]         crc_r;
    logic [1:0]          req_ready_r;
    logic                crc_valid_r;
    logic [15:0]         crc_out_r;
    logic                crc_id_r;
    logic                busy_r;

    logic                grant_sel_s;
    logic [WORD_W-1:0]   acc_word_s;
    logic                acc_valid_s;
    logic                acc_last_s;
    logic [15:0]         crc_next_s;

    // Arbitration choice and granted-requester muxing (no path to outputs).
    always_comb begin
        grant_sel_s = 1'b0;
        if (req_valid == 2'b11) begin
            grant_sel_s = ~last_grant_r;
        end else if (req_valid[1]) begin
            grant_sel_s = 1'b1;
        end else begin
            grant_sel_s = 1'b0;
        end
        if (grant_r) begin
            acc_word_s  = req_data[2*WORD_W-1:WORD_W];
            acc_valid_s = req_valid[1];
            acc_last_s  = req_last[1];
        end else begin
            acc_word_s  = req_data[WORD_W-1:0];
            acc_valid_s = req_valid[0];
            acc_last_s  = req_last[0];
        end
        crc_next_s = crc_step(crc_r, word_r[WORD_W-1]);
    end

    // Frame sequencer with all outputs registered from state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            first_r      <= 1'b0;
            last_r       <= 1'b0;
            word_r       <= {WORD_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            crc_r        <= SEED;
            req_ready_r  <= 2'b00;
            crc_valid_r  <= 1'b0;
            crc_out_r    <= 16'h0000;
            crc_id_r     <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|req_valid) begin
                        grant_r     <= grant_sel_s;
                        first_r     <= 1'b1;
                        req_ready_r <= onehot(grant_sel_s);
                        busy_r      <= 1'b1;
                        state_r     <= ST_ACCEPT;
                    end
                end
                ST_ACCEPT: begin
                    // Frame stays granted while the owner withholds valid.
                    if (acc_valid_s) begin
                        word_r      <= acc_word_s;
                        last_r      <= acc_last_s;
                        cnt_r       <= {CNT_W{1'b0}};
                        first_r     <= 1'b0;
                        req_ready_r <= 2'b00;
                        if (first_r) begin
                            crc_r <= SEED;
                        end
                        state_r     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    crc_r  <= crc_next_s;
                    word_r <= {word_r[WORD_W-2:0], 1'b0};
                    cnt_r  <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(WORD_W - 1)) begin
                        if (last_r) begin
                            crc_valid_r <= 1'b1;
                            crc_out_r   <= crc_next_s;
                            crc_id_r    <= grant_r;
                            state_r     <= ST_DONE;
                        end else begin
                            req_ready_r <= onehot(grant_r);
                            state_r     <= ST_ACCEPT;
                        end
                    end
                end
                ST_DONE: begin
                    if (crc_ready) begin
                        crc_valid_r  <= 1'b0;
                        last_grant_r <= grant_r;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 2'b00;
                    crc_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign crc_valid = crc_valid_r;
    assign crc_out   = crc_out_r;
    assign crc_id    = crc_id_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_crc16_frame_sched.sv
// Directed bench for crc16_frame_sched (WORD_W = 32). Works in both builds:
// with CRC16_SCHED_INIT_ONES_EN defined, directed expectations come from the
// bit-serial reference model seeded 0xFFFF instead of the hand values.
module tb_crc16_frame_sched;

    localparam int WORD_W = 32;
`ifdef CRC16_SCHED_INIT_ONES_EN
    localparam logic [15:0] SEED = 16'hFFFF;
`else
    localparam logic [15:0] SEED = 16'h0000;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [1:0]          req_valid;
    logic [2*WORD_W-1:0] req_data;
    logic [1:0]          req_last;
    logic [1:0]          req_ready;
    logic                crc_valid;
    logic [15:0]         crc_out;
    logic                crc_id;
    logic                crc_ready;
    logic                busy;

    crc16_frame_sched #(.WORD_W(WORD_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .crc_valid(crc_valid),
        .crc_out(crc_out), .crc_id(crc_id), .crc_ready(crc_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] fw [2][8];
    int          flen [2];
    int          fidx [2];
    bit          fact [2];
    bit          stall [2];
    int          rdy_cnt [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] model_frame(input int i);
        logic [15:0] c;
        logic        fb;
        c = SEED;
        for (int k = 0; k < flen[i]; k++) begin
            for (int b = 31; b >= 0; b--) begin
                fb = c[15] ^ fw[i][k][b];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    function automatic logic [15:0] expect_crc(input logic [15:0] hand, input int i);
        return (SEED == 16'h0000) ? hand : model_frame(i);
    endfunction

    task automatic apply();
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = fact[i] && !stall[i];
            req_data[i*WORD_W +: WORD_W] = fact[i] ? fw[i][fidx[i]] : 32'h0000_0000;
            req_last[i] = fact[i] && (fidx[i] == flen[i] - 1);
        end
    endtask

    task automatic load(input int i, input int n, input logic [31:0] w0,
                        input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3);
        fw[i][0] = w0; fw[i][1] = w1; fw[i][2] = w2; fw[i][3] = w3;
        flen[i] = n; fidx[i] = 0; fact[i] = 1'b1;
        apply();
    endtask

    // Advance one clock; retire handshaken words and re-drive requesters.
    task automatic tick();
        logic [1:0] hs;
        hs = req_ready & req_valid;
        for (int i = 0; i < 2; i++) rdy_cnt[i] += int'(req_ready[i]);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            if (hs[i]) begin
                fidx[i]++;
                if (fidx[i] >= flen[i]) fact[i] = 1'b0;
            end
        end
        apply();
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!crc_valid && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("result_timeout", {31'd0, crc_valid}, 32'd1);
    endtask

    initial begin
        int cyc;
        logic [15:0] hold_crc;
        rst_n = 1'b0; crc_ready = 1'b1;
        req_valid = 2'b00; req_data = '0; req_last = 2'b00;
        for (int i = 0; i < 2; i++) begin
            fact[i] = 1'b0; stall[i] = 1'b0; fidx[i] = 0; flen[i] = 1; rdy_cnt[i] = 0;
            for (int k = 0; k < 8; k++) fw[i][k] = 32'h0;
        end
        #22;
        chk("rst_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_valid", {31'd0, crc_valid}, 32'd0);
        chk("rst_crc", {16'd0, crc_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick(); tick();

        // Single word, latency and value
        load(0, 1, 32'h0000_0001, 32'h0, 32'h0, 32'h0);
        tick();
        chk("t1_ready", {30'd0, req_ready}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_valid(cyc);
        chk("t1_latency", cyc + 1, 32'd34);
        chk("t1_crc", {16'd0, crc_out}, {16'd0, expect_crc(16'h1021, 0)});
        chk("t1_id", {31'd0, crc_id}, 32'd0);
        tick(); tick();

        // Two-word frame on requester 1, ready pulse count
        rdy_cnt[0] = 0; rdy_cnt[1] = 0;
        load(1, 2, 32'h0000_0000, 32'h0000_0002, 32'h0, 32'h0);
        wait_valid(cyc);
        chk("t2_crc", {16'd0, crc_out}, {16'd0, expect_crc(16'h2042, 1)});
        chk("t2_id", {31'd0, crc_id}, 32'd1);
        chk("t2_ready1_cnt", rdy_cnt[1], 32'd2);
        chk("t2_ready0_cnt", rdy_cnt[0], 32'd0);
        tick(); tick();

        // Residue frame
        load(0, 2, 32'h0000_0001, 32'h1021_0000, 32'h0, 32'h0);
        wait_valid(cyc);
        chk("t3_residue", {16'd0, crc_out}, {16'd0, expect_crc(16'h0000, 0)});
        tick(); tick();

        // Fairness from reset, result stall
        rst_n = 1'b0; #3; rst_n = 1'b1;
        crc_ready = 1'b0;
        load(0, 1, 32'h0000_0001, 32'h0, 32'h0, 32'h0);
        load(1, 1, 32'h0000_0002, 32'h0, 32'h0, 32'h0);
        tick();
        chk("t4_first_grant", {30'd0, req_ready}, 32'd1);
        wait_valid(cyc);
        chk("t4_id0", {31'd0, crc_id}, 32'd0);
        chk("t4_crc0", {16'd0, crc_out}, {16'd0, expect_crc(16'h1021, 0)});
        hold_crc = expect_crc(16'h1021, 0);
        load(0, 1, 32'h0000_0003, 32'h0, 32'h0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_hold_valid", {31'd0, crc_valid}, 32'd1);
            chk("t4_hold_crc", {16'd0, crc_out}, {16'd0, hold_crc});
            chk("t4_hold_ready", {30'd0, req_ready}, 32'd0);
        end
        crc_ready = 1'b1;
        tick();
        chk("t4_idle_gap", {31'd0, busy}, 32'd0);
        tick();
        chk("t4_second_grant", {30'd0, req_ready}, 32'd2);
        wait_valid(cyc);
        chk("t4_id1", {31'd0, crc_id}, 32'd1);
        chk("t4_crc1", {16'd0, crc_out}, {16'd0, expect_crc(16'h2042, 1)});
        tick();
        wait_valid(cyc);
        chk("t4_id0b", {31'd0, crc_id}, 32'd0);
        chk("t4_crc0b", {16'd0, crc_out}, {16'd0, expect_crc(16'h3063, 0)});
        tick(); tick();

        // Asynchronous reset in the middle of the second word's shift
        load(1, 2, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0);
        for (int k = 0; k < 40; k++) tick();
        chk("t5_busy_pre", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", {30'd0, req_ready}, 32'd0);
        chk("t5_rst_valid", {31'd0, crc_valid}, 32'd0);
        chk("t5_rst_crc", {16'd0, crc_out}, 32'd0);
        chk("t5_rst_id", {31'd0, crc_id}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        fidx[1] = 0; fact[1] = 1'b1; apply();
        wait_valid(cyc);
        chk("t5_restart_crc", {16'd0, crc_out}, {16'd0, model_frame(1)});
        chk("t5_restart_id", {31'd0, crc_id}, 32'd1);
        tick(); tick();

        // Stall the owner in ACCEPT while the other requester waits
        load(0, 2, 32'hCAFE_F00D, 32'h0BAD_BEEF, 32'h0, 32'h0);
        load(1, 1, 32'h5555_AAAA, 32'h0, 32'h0, 32'h0);
        cyc = 0;
        while (fidx[0] == 0 && cyc < 100) begin tick(); cyc++; end
        stall[0] = 1'b1; apply();
        cyc = 0;
        while (req_ready[0] !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_stall_grant", {30'd0, req_ready}, 32'd1);
        end
        stall[0] = 1'b0; apply();
        wait_valid(cyc);
        chk("t6_stall_crc", {16'd0, crc_out}, {16'd0, model_frame(0)});
        chk("t6_stall_id", {31'd0, crc_id}, 32'd0);
        tick();
        wait_valid(cyc);
        chk("t6_other_crc", {16'd0, crc_out}, {16'd0, model_frame(1)});
        chk("t6_other_id", {31'd0, crc_id}, 32'd1);
        tick(); tick();

        // Random frames against the reference model
        for (int f = 0; f < 6; f++) begin
            load(f % 2, int'($urandom_range(4, 1)), $urandom(), $urandom(), $urandom(), $urandom());
            wait_valid(cyc);
            chk("t7_rand_crc", {16'd0, crc_out}, {16'd0, model_frame(f % 2)});
            chk("t7_rand_id", {31'd0, crc_id}, f % 2);
            tick(); tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
